cpu_run_ctrl: RTL and testbench

Execution sequencer for the single-cycle ARM core on the board. It replaces the ripple-derived slow clock with a one-cycle clock-enable pulse, `cpu_en`, in the 50 MHz domain. The core, `dmem` and `led_controller` advance state only on cycles with `cpu_en`=1. It supports free-run at a divided rate, single-step from a button, explicit halt, and a PC breakpoint, and it counts retired instructions for the LED/debug display.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/tick_gen.sv | 39 +++
 rtl/cpu_run_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared types and defaults for the CPU run controller      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        CS_HALT  = 2'd0,
        CS_RUN   = 2'd1,
        CS_STEP  = 2'd2,
        CS_BREAK = 2'd3
    } ctrl_state_t;

    localparam int DEFAULT_TICK_DIV = 50_000_000;

    // Divider width; a divide-by-one still needs a one-bit register.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_gen : clearable modulo-TICK_DIV divider with terminal-count output  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tick_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int               DIV_W = div_width(TICK_DIV);
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);
    // Clear wins so a cycle that leaves RUN can never report a tick.
    assign tc      = enable & ~clear & at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_run_ctrl : run/step/halt/breakpoint sequencer producing cpu_en       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             bp_hit
);

    ctrl_state_t cur_state;
    ctrl_state_t state_n;
    logic        cpu_en_n;
    logic        bp_hit_n;
    logic        step_q;
    logic        step_rise;
    logic        bp_match;
    logic        run_ok;
    logic        tick;

    assign state     = cur_state;
    assign step_rise = step_req & ~step_q;
    assign bp_match  = bp_en & (pc == bp_addr);
    // Divider only advances while RUN is going to be held this cycle.
    assign run_ok    = (cur_state == CS_RUN) & ~halt_req & run_req;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (~run_ok),
        .enable (run_ok),
        .tc     (tick)
    );

    always_comb begin
        state_n  = cur_state;
        cpu_en_n = 1'b0;
        bp_hit_n = bp_hit;
        case (cur_state)
            CS_HALT: begin
                if (halt_req) begin
                    state_n = CS_HALT;
                end else if (step_rise) begin
                    state_n  = CS_STEP;
                    cpu_en_n = 1'b1;
                end else if (run_req) begin
                    state_n  = CS_RUN;
                    bp_hit_n = 1'b0;
                end
            end
            CS_RUN: begin
                if (halt_req || !run_req) begin
                    state_n = CS_HALT;
                end else if (tick) begin
                    if (bp_match) begin
                        state_n  = CS_BREAK;
                        bp_hit_n = 1'b1;
                    end else begin
                        cpu_en_n = 1'b1;
                    end
                end
            end
            CS_STEP: begin
                state_n = CS_HALT;
            end
            CS_BREAK: begin
                if (halt_req || !run_req) begin
                    state_n = CS_HALT;
                end else if (step_rise) begin
                    state_n  = CS_STEP;
                    cpu_en_n = 1'b1;
                end
            end
            default: begin
                state_n = CS_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= CS_HALT;
            cpu_en    <= 1'b0;
            retired   <= '0;
            bp_hit    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            cur_state <= state_n;
            cpu_en    <= cpu_en_n;
            bp_hit    <= bp_hit_n;
            step_q    <= step_req;
            if (cpu_en) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_run_ctrl : directed scenarios plus random stimulus vs. a model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_run_ctrl;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] retired;
    logic             bp_hit;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode code, cycles spent in RUN since entry, pulse history.
    int          m_mode;
    int          m_age;
    logic        m_en;
    longint      m_ret;
    logic        m_hit;
    logic        m_stepq;
    logic        prev_en;

    cpu_run_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_req  (run_req),
        .step_req (step_req),
        .halt_req (halt_req),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cpu_en   (cpu_en),
        .state    (state),
        .retired  (retired),
        .bp_hit   (bp_hit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Spec rules applied to inputs present at the clock edge.
    task automatic model_update();
        logic rise;
        logic nxt_en;
        rise   = step_req & ~m_stepq;
        nxt_en = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_age   = 0;
            m_en    = 1'b0;
            m_ret   = 0;
            m_hit   = 1'b0;
            m_stepq = 1'b0;
        end else begin
            if (m_en) m_ret = m_ret + 1;
            case (m_mode)
                0: begin
                    if (halt_req) ;
                    else if (rise) begin m_mode = 2; nxt_en = 1'b1; end
                    else if (run_req) begin m_mode = 1; m_age = 0; m_hit = 1'b0; end
                end
                1: begin
                    if (halt_req || !run_req) m_mode = 0;
                    else begin
                        m_age = m_age + 1;
                        if (m_age % TICK_DIV == 0) begin
                            if (bp_en && (pc == bp_addr)) begin m_mode = 3; m_hit = 1'b1; end
                            else nxt_en = 1'b1;
                        end
                    end
                end
                2: m_mode = 0;
                default: begin
                    if (halt_req || !run_req) m_mode = 0;
                    else if (rise) begin m_mode = 2; nxt_en = 1'b1; end
                end
            endcase
            m_en    = nxt_en;
            m_stepq = step_req;
        end
    endtask

    // One clock: advance model, then compare DUT outputs 1 time unit after the edge.
    task automatic step_cycle();
        @(posedge clk);
        model_update();
        #1;
        pc = 32'(m_ret * 4);
        check_val("state",   64'(state),   64'(m_mode));
        check_val("cpu_en",  64'(cpu_en),  64'(m_en));
        check_val("retired", 64'(retired), 64'(m_ret[CNT_W-1:0]));
        check_val("bp_hit",  64'(bp_hit),  64'(m_hit));
        check_val("no_b2b",  64'(cpu_en & prev_en), 64'(0));
        prev_en = cpu_en;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_req = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 32'h0;
        step_cycle();
        step_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        m_mode = 0; m_age = 0; m_en = 1'b0; m_ret = 0; m_hit = 1'b0; m_stepq = 1'b0;
        prev_en = 1'b0;
        pc = 32'h0;

        // Scenario 1: free run from reset release.
        do_reset();
        check_val("rst_state",   64'(state),   64'(0));
        check_val("rst_retired", 64'(retired), 64'(0));
        run_req = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step_cycle();
            if (k == 1) check_val("s1_run_entry", 64'(state), 64'(1));
            check_val($sformatf("s1_en_c%0d", k), 64'(cpu_en), 64'((k == 5) || (k == 9) || (k == 13)));
        end
        step_cycle();
        check_val("s1_retired", 64'(retired), 64'(3));

        // Scenario 2: held step button gives exactly one pulse.
        do_reset();
        step_cycle();
        step_req = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            if (k == 1) check_val("s2_step_state", 64'(state), 64'(2));
            if (k == 2) check_val("s2_back_halt", 64'(state), 64'(0));
            if (cpu_en) pulses++;
        end
        check_val("s2_pulses",  64'(pulses),  64'(1));
        check_val("s2_retired", 64'(retired), 64'(1));

        // Scenario 3: breakpoint at 0x8.
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'h8;
        run_req = 1'b1;
        pulses  = 0;
        for (int k = 1; k <= 33; k++) begin
            step_cycle();
            if (cpu_en) pulses++;
        end
        check_val("s3_pulses", 64'(pulses), 64'(2));
        check_val("s3_state",  64'(state),  64'(3));
        check_val("s3_bp_hit", 64'(bp_hit), 64'(1));
        check_val("s3_pc",     64'(pc),     64'(32'h8));

        // Scenario 4: step out of the breakpoint, then resume running.
        step_req = 1'b1;
        step_cycle();
        check_val("s4_step",    64'(state),  64'(2));
        check_val("s4_step_en", 64'(cpu_en), 64'(1));
        step_cycle();
        check_val("s4_halt",    64'(state),  64'(0));
        check_val("s4_pc",      64'(pc),     64'(32'hC));
        step_cycle();
        check_val("s4_run",     64'(state),  64'(1));
        check_val("s4_bp_clr",  64'(bp_hit), 64'(0));
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step_cycle();
            if (cpu_en) pulses++;
        end
        check_val("s4_pulses", 64'(pulses), 64'(2));

        // Scenario 5: halt plus step edge while divider==2.
        do_reset();
        run_req = 1'b1;
        for (int k = 1; k <= 3; k++) step_cycle();
        halt_req = 1'b1;
        step_req = 1'b1;
        step_cycle();
        check_val("s5_state",   64'(state),   64'(0));
        check_val("s5_en",      64'(cpu_en),  64'(0));
        check_val("s5_retired", 64'(retired), 64'(0));
        halt_req = 1'b0;
        step_cycle();
        check_val("s5_rerun", 64'(state), 64'(1));
        for (int k = 1; k <= TICK_DIV; k++) begin
            step_cycle();
            check_val($sformatf("s5_en_c%0d", k), 64'(cpu_en), 64'(k == TICK_DIV));
        end

        // Scenario 6: reset exactly when the divider is at its last count.
        do_reset();
        run_req = 1'b1;
        for (int k = 1; k <= 8; k++) step_cycle();
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        check_val("s6_en",      64'(cpu_en),  64'(0));
        check_val("s6_state",   64'(state),   64'(0));
        check_val("s6_retired", 64'(retired), 64'(0));
        check_val("s6_bp_hit",  64'(bp_hit),  64'(0));

        // Randomized phase.
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(0, 199) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) run_req = ~run_req;
            if ($urandom_range(0, 4) == 0) step_req = ~step_req;
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 39) == 0) bp_addr = 32'(4 * $urandom_range(0, 12));
            step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
